// File: rtl/sorter_pkg.sv
// Shared constants and helpers for the sorter pipeline.
package sorter_pkg;

  localparam int unsigned DefWidth = 32;
  localparam int unsigned DefN     = 8;

  // Largest two's-complement value of the given width (valid for width <= 64).
  function automatic logic [63:0] pad_max(int unsigned width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  // Bits needed to hold an element count in 0..n.
  function automatic int unsigned count_w(int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/vec_reg.sv
// Output holding register with valid/ready: load sets valid, a handshake without load clears it.
module vec_reg #(
  parameter int unsigned Width = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [Width-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [Width-1:0] data_q, data_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load_i) begin
      data_d  = data_i;
      valid_d = 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/sort_loader.sv
// sort_loader: packs N signed words into a flat frame via a collector plus output register.
// Define SORT_LOADER_FLUSH_EN to add in_last/out_count and max-value padding of short frames.
module sort_loader
  import sorter_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned N     = DefN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
`ifdef SORT_LOADER_FLUSH_EN
  input  logic                  in_last,
  output logic [count_w(N)-1:0] out_count,
`endif
  output logic [N*WIDTH-1:0]    out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int unsigned CntW = $clog2(N);
`ifdef SORT_LOADER_FLUSH_EN
  localparam int unsigned CW = count_w(N);
  localparam logic [WIDTH-1:0] PadVal = WIDTH'(pad_max(WIDTH));
  localparam int unsigned VecW = N * WIDTH + CW;
`else
  localparam int unsigned VecW = N * WIDTH;
`endif

  logic [WIDTH-1:0]   col_q [N];
  logic [WIDTH-1:0]   col_d [N];
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               col_full_q, col_full_d;
  logic [N*WIDTH-1:0] frame, col_flat, load_data;
  logic               in_hs, out_free, last_hit, load;
  logic [VecW-1:0]    load_vec, out_vec;

  assign in_ready = !col_full_q;
  assign in_hs    = in_valid && in_ready;
  assign out_free = !out_valid || out_ready;

`ifdef SORT_LOADER_FLUSH_EN
  assign last_hit = (cnt_q == CntW'(N - 1)) || in_last;
`else
  assign last_hit = (cnt_q == CntW'(N - 1));
`endif

  // Frame as it would look if the incoming word completes it right now.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      col_flat[i*WIDTH +: WIDTH] = col_q[i];
      frame[i*WIDTH +: WIDTH]    = col_q[i];
      if (CntW'(i) == cnt_q) begin
        frame[i*WIDTH +: WIDTH] = in_data;
`ifdef SORT_LOADER_FLUSH_EN
      end else if (CntW'(i) > cnt_q) begin
        frame[i*WIDTH +: WIDTH] = PadVal;
`endif
      end
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    col_full_d = col_full_q;
    col_d      = col_q;
    load       = 1'b0;
    load_data  = frame;
    if (col_full_q) begin
      if (out_free) begin
        load       = 1'b1;
        load_data  = col_flat;
        col_full_d = 1'b0;
      end
    end else if (in_hs) begin
      if (last_hit) begin
        cnt_d = '0;
        if (out_free) begin
          load = 1'b1;
        end else begin
          col_full_d = 1'b1;
          for (int i = 0; i < N; i++) col_d[i] = frame[i*WIDTH +: WIDTH];
        end
      end else begin
        cnt_d        = cnt_q + CntW'(1);
        col_d[cnt_q] = in_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      col_full_q <= 1'b0;
      for (int i = 0; i < N; i++) col_q[i] <= '0;
    end else begin
      cnt_q      <= cnt_d;
      col_full_q <= col_full_d;
      col_q      <= col_d;
    end
  end

`ifdef SORT_LOADER_FLUSH_EN
  logic [CW-1:0] col_cnt_q, frame_cnt, load_cnt;

  assign frame_cnt = CW'(cnt_q) + CW'(1);
  assign load_cnt  = col_full_q ? col_cnt_q : frame_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt_q <= '0;
    end else if (!col_full_q && in_hs && last_hit && !out_free) begin
      col_cnt_q <= frame_cnt;
    end
  end

  assign load_vec  = {load_cnt, load_data};
  assign out_count = out_vec[VecW-1 -: CW];
`else
  assign load_vec = load_data;
`endif

  vec_reg #(
    .Width(VecW)
  ) u_out_reg (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .data_i (load_vec),
    .ready_i(out_ready),
    .valid_o(out_valid),
    .data_o (out_vec)
  );

  assign out_data = out_vec[N*WIDTH-1:0];

endmodule

// File: tb/tb_sort_loader.sv
// Bench for sort_loader: frame-queue reference model plus directed literal checks.
module tb_sort_loader;

  localparam int W  = 32;
  localparam int N  = 8;
  localparam int CW = 4;
  localparam logic [W-1:0] PAD = 32'h7fff_ffff;
`ifdef SORT_LOADER_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  typedef struct {
    logic [N*W-1:0] d;
    int             c;
  } frame_t;

  logic           clk = 1'b0;
  logic           rst, in_valid, in_last, in_ready, out_valid, out_ready;
  logic [W-1:0]   in_data;
  logic [N*W-1:0] out_data;
  logic [CW-1:0]  out_count;

  int checks = 0;
  int errors = 0;

  // Model: words of the frame being collected, and completed frames still held
  // (head is the one presented on out_data).
  logic [W-1:0] part[$];
  frame_t       fq[$];
  frame_t       shown;

  always #5 clk = ~clk;

  sort_loader dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
`ifdef SORT_LOADER_FLUSH_EN
    .in_last  (in_last),
    .out_count(out_count),
`endif
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

`ifndef SORT_LOADER_FLUSH_EN
  assign out_count = '0;
`endif

  task automatic chk(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    part.delete();
    fq.delete();
    shown.d = '0;
    shown.c = 0;
  endtask

  task automatic model_update();
    bit ihs, ohs;
    if (rst) begin
      model_reset();
      return;
    end
    ihs = in_valid && (fq.size() < 2);
    ohs = (fq.size() > 0) && out_ready;
    if (ohs) void'(fq.pop_front());
    if (ihs) begin
      part.push_back(in_data);
      if (part.size() == N || (FLUSH && in_last)) begin
        frame_t f;
        f.c = part.size();
        for (int i = 0; i < N; i++) f.d[i*W +: W] = (i < part.size()) ? part[i] : PAD;
        fq.push_back(f);
        part.delete();
      end
    end
    if (fq.size() > 0) shown = fq[0];
  endtask

  task automatic compare();
    chk("in_ready", in_ready, fq.size() < 2);
    chk("out_valid", out_valid, fq.size() > 0);
    chk("out_data", out_data, shown.d);
`ifdef SORT_LOADER_FLUSH_EN
    chk("out_count", out_count, CW'(shown.c));
`endif
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    logic [W-1:0]   words[$];
    logic [W-1:0]   neg[N];
    logic [N*W-1:0] exp_v;
    int             acc;

    model_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    tick();
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    repeat (2) tick();
    rst = 1'b0;

    // Stream 1..8 with out_ready high.
    out_ready = 1'b1;
    for (int i = 1; i <= N; i++) begin
      in_valid = 1'b1;
      in_data  = W'(i);
      tick();
      if (i < N) chk("seq_no_early_valid", out_valid, 0);
    end
    in_valid = 1'b0;
    chk("seq_valid", out_valid, 1);
    for (int i = 0; i < N; i++) chk("seq_elem", out_data[i*W +: W], W'(i + 1));
    tick();
    chk("seq_valid_one_cycle", out_valid, 0);

    // 24 back-to-back random words.
    for (int i = 0; i < 3 * N; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom();
      tick();
    end
    drain();

    // Backpressure: 20 offered words, only 2N fit.
    out_ready = 1'b0;
    acc = 0;
    words.delete();
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom();
      if (in_ready) begin
        acc++;
        words.push_back(in_data);
      end
      tick();
    end
    in_valid = 1'b0;
    chk("bp_accepted", acc, 2 * N);
    chk("bp_in_ready_low", in_ready, 0);
    for (int i = 0; i < N; i++) exp_v[i*W +: W] = words[i];
    chk("bp_frame1", out_data, exp_v);
    out_ready = 1'b1;
    tick();
    for (int i = 0; i < N; i++) exp_v[i*W +: W] = words[N + i];
    chk("bp_frame2_valid", out_valid, 1);
    chk("bp_frame2", out_data, exp_v);
    tick();
    chk("bp_drained", out_valid, 0);
    chk("bp_in_ready_back", in_ready, 1);

    // Negative and extreme values pass through bit-exact.
    neg[0] = -32'sd5; neg[1] = 32'd3; neg[2] = 32'h8000_0000; neg[3] = 32'hffff_ffff;
    neg[4] = 32'h7fff_ffff; neg[5] = 32'd0; neg[6] = -32'sd128; neg[7] = 32'd1;
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_data  = neg[i];
      exp_v[i*W +: W] = neg[i];
      tick();
    end
    in_valid = 1'b0;
    chk("neg_frame", out_data, exp_v);
    chk("neg_elem0", out_data[W-1:0], 32'hffff_fffb);
    drain();

    // Reset in the middle of a frame.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom();
      tick();
    end
    rst = 1'b1;
    model_reset();
    #1;
    chk("midrst_valid", out_valid, 0);
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_data  = W'(32'h100 + i);
      exp_v[i*W +: W] = W'(32'h100 + i);
      tick();
      if (i < N - 1) chk("midrst_no_partial", out_valid, 0);
    end
    in_valid = 1'b0;
    chk("midrst_valid_after", out_valid, 1);
    chk("midrst_frame", out_data, exp_v);
    drain();

`ifdef SORT_LOADER_FLUSH_EN
    // Short frame of three words.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_last  = (i == 2);
      in_data  = W'(32'h50 + i);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("flush_count", out_count, 3);
    chk("flush_elem2", out_data[2*W +: W], 32'h52);
    for (int i = 3; i < N; i++) chk("flush_pad", out_data[i*W +: W], 32'h7fff_ffff);
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_data  = W'(32'h60 + i);
      tick();
    end
    in_valid = 1'b0;
    chk("flush_next_slot0", out_data[W-1:0], 32'h60);
    chk("flush_next_count", out_count, 8);
    drain();
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom();
      in_last   = FLUSH && ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
